// File: rtl/chip8_pkg.sv
// chip8_pkg: shared constants and types for CHIP-8 framebuffer readers.
//   DISP_W/DISP_H  display geometry in pixels
//   DISP_BITS      packed framebuffer width (one bit per pixel)
//   FRAME_BYTES    bytes per streamed frame (8 pixels per byte)
//   stream_state_e frame streamer FSM states
package chip8_pkg;

    localparam int unsigned DISP_W      = 64;
    localparam int unsigned DISP_H      = 32;
    localparam int unsigned DISP_BITS   = DISP_W * DISP_H;
    localparam int unsigned FRAME_BYTES = DISP_BITS / 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM
    } stream_state_e;

endpackage

// File: rtl/chip8_fb_byte_sel.sv
// chip8_fb_byte_sel: combinational 256:1 byte mux over a packed framebuffer.
//   i_vec    packed framebuffer, pixel (col,row) at bit 2047-(row*64+col)
//   i_index  byte index 0..255 in raster order
//   o_byte   8 pixels, bit 7 = leftmost
module chip8_fb_byte_sel
    import chip8_pkg::*;
(
    input  logic [DISP_BITS-1:0] i_vec,
    input  logic [7:0]           i_index,
    output logic [7:0]           o_byte
);

    // Byte k occupies bits [2047-8k -: 8]; the MSB of the byte is the leftmost pixel.
    logic [10:0] w_msb;

    assign w_msb  = 11'(DISP_BITS - 1) - {i_index, 3'b000};
    assign o_byte = i_vec[w_msb -: 8];

endmodule

// File: rtl/chip8_frame_streamer.sv
// chip8_frame_streamer: snapshots the CHIP-8 framebuffer on request and streams it
// as 256 raster-order bytes over valid/ready, optionally dropping unchanged frames.
//   clk, reset_n      clock, asynchronous active-low reset
//   frame_req         request a frame (queued one deep, merges while busy)
//   force_send        stream even if unchanged (merged with the request)
//   display_in        packed framebuffer
//   m_valid/m_ready   stream handshake; m_data, m_index, m_first, m_last beat payload
//   busy              request queued or frame in CHECK/STREAM
//   frame_done        pulse after byte 255 transfers
//   frame_skipped     pulse when a frame is dropped as unchanged
module chip8_frame_streamer
    import chip8_pkg::*;
#(
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_req,
    input  logic                 force_send,
    input  logic [DISP_BITS-1:0] display_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic [7:0]           m_index,
    output logic                 m_first,
    output logic                 m_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_skipped
);

    stream_state_e        r_state, w_state_d;
    logic [DISP_BITS-1:0] r_shadow, w_shadow_d;
    logic [DISP_BITS-1:0] r_last_sent, w_last_sent_d;
    logic                 r_last_valid, w_last_valid_d;
    logic                 r_pend, w_pend_d;
    logic                 r_pend_force, w_pend_force_d;
    logic                 r_force, w_force_d;
    logic [7:0]           r_idx, w_idx_d;
    logic                 r_busy, w_busy_d;
    logic                 r_done, w_done_d;
    logic                 r_skipped, w_skipped_d;
    logic                 w_unchanged;
    logic [7:0]           w_byte;

    chip8_fb_byte_sel u_byte_sel (
        .i_vec   (r_shadow),
        .i_index (r_idx),
        .o_byte  (w_byte)
    );

    assign w_unchanged = r_last_valid && (r_shadow == r_last_sent);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_last_sent  <= '0;
            r_last_valid <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_force <= 1'b0;
            r_force      <= 1'b0;
            r_idx        <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_skipped    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shadow     <= w_shadow_d;
            r_last_sent  <= w_last_sent_d;
            r_last_valid <= w_last_valid_d;
            r_pend       <= w_pend_d;
            r_pend_force <= w_pend_force_d;
            r_force      <= w_force_d;
            r_idx        <= w_idx_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_skipped    <= w_skipped_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_shadow_d     = r_shadow;
        w_last_sent_d  = r_last_sent;
        w_last_valid_d = r_last_valid;
        w_pend_d       = r_pend;
        w_pend_force_d = r_pend_force;
        w_force_d      = r_force;
        w_idx_d        = r_idx;
        w_done_d       = 1'b0;
        w_skipped_d    = 1'b0;

        unique case (r_state)
            IDLE: begin
                // The snapshot is taken when the queued request is serviced.
                if (r_pend) begin
                    w_shadow_d     = display_in;
                    w_force_d      = r_pend_force;
                    w_pend_d       = 1'b0;
                    w_pend_force_d = 1'b0;
                    w_state_d      = CHECK;
                end
            end
            CHECK: begin
                if (SKIP_UNCHANGED && w_unchanged && !r_force) begin
                    w_skipped_d = 1'b1;
                    w_state_d   = IDLE;
                end else begin
                    w_idx_d   = 8'd0;
                    w_state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (r_idx == 8'd255) begin
                        w_last_sent_d  = r_shadow;
                        w_last_valid_d = 1'b1;
                        w_done_d       = 1'b1;
                        w_state_d      = IDLE;
                    end else begin
                        w_idx_d = r_idx + 8'd1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Every request goes through the one-deep queue; a request on the same
        // edge as a service starts a fresh pending entry.
        if (frame_req) begin
            w_pend_d       = 1'b1;
            w_pend_force_d = w_pend_force_d | force_send;
        end

        w_busy_d = (w_state_d != IDLE) || w_pend_d;
    end

    assign m_valid       = (r_state == STREAM);
    assign m_data        = m_valid ? w_byte : 8'd0;
    assign m_index       = m_valid ? r_idx : 8'd0;
    assign m_first       = m_valid && (r_idx == 8'd0);
    assign m_last        = m_valid && (r_idx == 8'd255);
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign frame_skipped = r_skipped;

endmodule
